test_seq: RTL and testbench

//  Serial overlapping sequence detector. Samples one bit of din per clock, tracks the longest

---
 rtl/seq_pkg.sv | 66 ++++++
 rtl/test_seq.sv | 48 ++++
 tb/tb_test_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// The detector state is the matched-prefix length, so the transition table is
// derived from the pattern with a KMP-style failure computation.
package seq_pkg;

  localparam int MAX_LEN = 16;
  localparam int MAX_SW  = 5;   // $clog2(MAX_LEN+1)

  localparam int         DEFAULT_LEN     = 5;
  localparam logic [4:0] DEFAULT_PATTERN = 5'b10010;

  // next[m][b]: new prefix length after sampling bit b with m bits matched
  typedef logic [MAX_LEN-1:0][1:0][MAX_SW-1:0] next_tbl_t;

  // Pattern bit in arrival order: i = 0 is the first bit received (the MSB)
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pat, input int len, input int i);
    return pat[4'(len - 1 - i)];
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it
  function automatic int border_len(input logic [MAX_LEN-1:0] pat, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pat_bit(pat, len, i) != pat_bit(pat, len, len - k + i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // For every (m, b): the matched string is the first m pattern bits followed by b.
  // The new state is the longest prefix of the pattern (shorter than the whole
  // pattern) that is a suffix of that string. On a full match this reduces to
  // border_len, which is what makes overlapping occurrences detectable.
  function automatic next_tbl_t build_next(input logic [MAX_LEN-1:0] pat, input int len);
    next_tbl_t tbl;
    int        kmax;
    int        best;
    int        j;
    logic      ok;
    logic      sbit;
    tbl = '0;
    for (int m = 0; m < len; m++) begin
      for (int b = 0; b < 2; b++) begin
        kmax = (m + 1 < len) ? m + 1 : len - 1;
        best = 0;
        for (int k = 1; k <= kmax; k++) begin
          ok = 1'b1;
          for (int i = 0; i < k; i++) begin
            j    = m + 1 - k + i;
            sbit = (j == m) ? b[0] : pat_bit(pat, len, j);
            if (sbit != pat_bit(pat, len, i)) ok = 1'b0;
          end
          if (ok) best = k;
        end
        tbl[4'(m)][b[0]] = MAX_SW'(best);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/test_seq.sv
// Overlapping serial sequence detector. Tracks the longest matched prefix of
// PATTERN (MSB first) and emits a one-cycle registered pulse per full match.
module test_seq
  import seq_pkg::*;
#(
  parameter int             LEN     = DEFAULT_LEN,
  parameter logic [LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int        SW   = $clog2(LEN + 1);
  localparam next_tbl_t NEXT = build_next(MAX_LEN'(PATTERN), LEN);

  logic [SW-1:0] state_reg;
  logic [SW-1:0] state_next;
  logic          match;
  logic [3:0]    idx;

  assign idx = 4'(state_reg);

  // Table lookup for the next prefix length and the completed-match flag;
  // encodings at or above LEN fall back to the empty prefix.
  always_comb begin
    state_next = '0;
    match      = 1'b0;
    if (state_reg < SW'(LEN)) begin
      state_next = NEXT[idx][din][SW-1:0];
      match      = (state_reg == SW'(LEN - 1)) && (din == PATTERN[0]);
    end
  end

  // Matched-prefix length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= '0;
    else        state_reg <= state_next;
  end

  // Detect pulse, high for the cycle after the edge that sampled the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 1'b0;
    else        dout <= match;
  end

endmodule

// File: tb/tb_test_seq.sv
// Directed bench for test_seq: every sampled bit pushes the expected dout onto a
// scoreboard, computed from a plain history window of the last five bits.
module tb_test_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic din   = 1'b0;
  logic dout;

  always #5 clk = ~clk;

  test_seq #(.LEN(5), .PATTERN(5'b10010)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout)
  );

  logic        exp_q[$];
  int          n_vec  = 0;
  int          n_err  = 0;
  int          pulses = 0;
  int          nbits  = 0;
  logic [4:0]  hist   = '0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one bit, predict, then compare just after the sampling edge
  task automatic send_bit(input logic b, input string tag);
    logic e;
    @(negedge clk);
    din   = b;
    hist  = {hist[3:0], b};
    nbits++;
    exp_q.push_back((nbits >= 5) && (hist == 5'b10010));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, dout, e);
    if (dout === 1'b1) pulses++;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], tag);
  endtask

  // Asynchronous reset for three cycles with din undefined
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    din   = 1'bx;
    hist  = '0;
    nbits = 0;
    #1;
    check({tag, "_async"}, dout, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, dout, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    din   = 1'b0;
  endtask

  initial begin
    logic [23:0] circ;

    do_reset("reset_initial");

    pulses = 0;
    send_bits(32'b10010, 5, "single");
    check_int("single_count", pulses, 1);

    // Reset while the pulse is high must drop it at once
    do_reset("reset_after_pulse");

    pulses = 0;
    send_bits(32'b10010010, 8, "overlap");
    check_int("overlap_count", pulses, 2);

    do_reset("reset_near_miss");
    pulses = 0;
    send_bits(32'b1001110010, 10, "near_miss");
    check_int("near_miss_count", pulses, 1);

    do_reset("reset_circ");
    pulses = 0;
    circ   = 24'b1010_0101_1001_0101_0100_1001;
    for (int c = 0; c < 72; c++) begin
      send_bit(circ[23], $sformatf("circ_bit%0d", c % 24));
      circ = {circ[22:0], circ[23]};
    end
    check_int("circ_count", pulses, 9);

    // Progress 1001 discarded by reset: a following 0 must not complete a match
    pulses = 0;
    send_bits(32'b1001, 4, "pre_reset");
    do_reset("reset_mid");
    send_bit(1'b0, "post_reset_zero");
    check_int("post_reset_zero_count", pulses, 0);
    send_bits(32'b10010, 5, "post_reset_match");
    check_int("post_reset_match_count", pulses, 1);

    check_int("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
